i2c_master_burst: RTL

I2C_MASTER_BURST -- requirements
Module: i2c_master_burst

---
 rtl/i2c_master_burst.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_burst.sv
// i2c_master_burst
//   Single-master I2C burst engine. One accepted request produces START,
//   the 7-bit address plus R/W bit, then len data bytes (written from
//   data_write_master or read into data_read_master), then STOP.
//   len = 0 performs an address-only probe. No clock stretching.
//
// Ports
//   clk, rst            system clock; synchronous active-low reset
//   enable              start request, honoured only while ready = 1
//   addr, rw, len       transfer descriptor, latched on accepted enable
//   data_write_master   next byte to send, latched at the start of each byte
//   wr_next             1-clk pulse after a write byte has been latched
//   data_read_master    last received byte; rd_valid pulses on update
//   ready               high only while idle
//   done                1-clk pulse when STOP completes
//   nack                sticky: slave did not acknowledge; cleared on enable
//   i2c_sda, i2c_scl    open-drain bus lines (driven 0 or released)
module i2c_master_burst #(
    parameter int DIV   = 5,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [6:0]       addr,
    input  logic             rw,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       data_write_master,
    output logic             wr_next,
    output logic [7:0]       data_read_master,
    output logic             rd_valid,
    output logic             ready,
    output logic             done,
    output logic             nack,
    inout  wire              i2c_sda,
    output wire              i2c_scl
);

    localparam int QW = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, STOP
    } state_t;

    state_t           state, state_n;
    logic [QW-1:0]    qcnt;
    logic [1:0]       phase;
    logic [2:0]       bit_cnt;
    logic [6:0]       tx_sh;      // bits still to be sent after the one on the bus
    logic [6:0]       rx_sh;
    logic [LEN_W-1:0] byte_cnt;
    logic [6:0]       addr_q;
    logic             rw_q;
    logic             scl_low;
    logic             sda_low;
    logic             ack_smp;
    logic             wr_pend;
    logic             tick;
    logic             slot_end;

    assign i2c_scl = scl_low ? 1'b0 : 1'bz;
    assign i2c_sda = sda_low ? 1'b0 : 1'bz;
    assign ready   = (state == IDLE);

    always_comb begin
        tick     = (qcnt == QW'(DIV - 1));
        slot_end = tick && (phase == 2'd3);
        state_n  = state;
        case (state)
            IDLE:     if (enable) state_n = START;
            START:    if (tick && phase == 2'd2) state_n = ADDR;
            ADDR:     if (slot_end && bit_cnt == 3'd0) state_n = ADDR_ACK;
            ADDR_ACK: if (slot_end) begin
                          if (ack_smp)                state_n = STOP;
                          else if (byte_cnt == '0)    state_n = STOP;
                          else if (rw_q)              state_n = RDATA;
                          else                        state_n = WDATA;
                      end
            WDATA:    if (slot_end && bit_cnt == 3'd0) state_n = WACK;
            WACK:     if (slot_end) begin
                          if (ack_smp || byte_cnt == LEN_W'(1)) state_n = STOP;
                          else                                  state_n = WDATA;
                      end
            RDATA:    if (slot_end && bit_cnt == 3'd0) state_n = RACK;
            RACK:     if (slot_end) begin
                          if (byte_cnt == LEN_W'(1)) state_n = STOP;
                          else                       state_n = RDATA;
                      end
            STOP:     if (tick && phase == 2'd2) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            qcnt             <= '0;
            phase            <= 2'd0;
            bit_cnt          <= 3'd0;
            byte_cnt         <= '0;
            scl_low          <= 1'b0;
            sda_low          <= 1'b0;
            wr_pend          <= 1'b0;
            wr_next          <= 1'b0;
            rd_valid         <= 1'b0;
            done             <= 1'b0;
            nack             <= 1'b0;
            data_read_master <= 8'h00;
        end else begin
            state    <= state_n;
            wr_pend  <= 1'b0;
            wr_next  <= wr_pend;
            rd_valid <= 1'b0;
            done     <= 1'b0;

            if (state == IDLE) begin
                qcnt    <= '0;
                phase   <= 2'd0;
                scl_low <= 1'b0;
                sda_low <= 1'b0;
                if (enable) begin
                    addr_q   <= addr;
                    rw_q     <= rw;
                    byte_cnt <= len;
                    nack     <= 1'b0;
                end
            end else begin
                qcnt <= tick ? '0 : qcnt + 1'b1;
                // START and STOP last three quarters; bit slots last four
                if (tick) begin
                    if ((state == START || state == STOP) && phase == 2'd2)
                        phase <= 2'd0;
                    else
                        phase <= phase + 2'd1;
                end

                case (state)
                    START: if (tick) begin
                        case (phase)
                            2'd0:    sda_low <= 1'b1;
                            2'd1:    scl_low <= 1'b1;
                            default: begin
                                sda_low <= ~addr_q[6];
                                tx_sh   <= {addr_q[5:0], rw_q};
                                bit_cnt <= 3'd7;
                            end
                        endcase
                    end
                    STOP: if (tick) begin
                        case (phase)
                            2'd0:    scl_low <= 1'b0;
                            2'd1:    sda_low <= 1'b0;
                            default: done    <= 1'b1;
                        endcase
                    end
                    default: begin
                        if (tick && phase == 2'd0) scl_low <= 1'b0;
                        if (tick && phase == 2'd2) scl_low <= 1'b1;
                        // sample on entry to p2, after SCL has been high a quarter
                        if (tick && phase == 2'd1) begin
                            ack_smp <= i2c_sda;
                            if (state == RDATA) begin
                                rx_sh <= {rx_sh[5:0], i2c_sda};
                                if (bit_cnt == 3'd0) begin
                                    data_read_master <= {rx_sh, i2c_sda};
                                    rd_valid         <= 1'b1;
                                end
                            end
                        end
                        if (slot_end) begin
                            if ((state == ADDR_ACK || state == WACK) && ack_smp)
                                nack <= 1'b1;
                            if (((state == WACK) && !ack_smp) || state == RACK)
                                byte_cnt <= (byte_cnt != '0) ? byte_cnt - 1'b1 : byte_cnt;
                            case (state_n)
                                ADDR, WDATA: begin
                                    if (state == state_n) begin
                                        sda_low <= ~tx_sh[6];
                                        tx_sh   <= {tx_sh[5:0], 1'b0};
                                        bit_cnt <= bit_cnt - 3'd1;
                                    end else begin
                                        sda_low <= ~data_write_master[7];
                                        tx_sh   <= data_write_master[6:0];
                                        bit_cnt <= 3'd7;
                                        wr_pend <= 1'b1;
                                    end
                                end
                                RDATA: begin
                                    sda_low <= 1'b0;
                                    bit_cnt <= (state == RDATA) ? bit_cnt - 3'd1 : 3'd7;
                                end
                                ADDR_ACK, WACK: sda_low <= 1'b0;
                                // ACK while more bytes are wanted, NACK the last one
                                RACK:    sda_low <= (byte_cnt != LEN_W'(1));
                                STOP:    sda_low <= 1'b1;
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule
